// File: rtl/fnv_pkg.sv
// fnv_pkg: shared constants, state encoding and FNV-1a step for the hash front end
package fnv_pkg;
  localparam logic [31:0] FnvOffsetBasis = 32'h811C9DC5;
  localparam logic [31:0] FnvPrime = 32'h01000193;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEED = 2'd1;
  localparam state_t ST_HASH = 2'd2;
  localparam state_t ST_DONE = 2'd3;
  function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
    return (h ^ {24'h0, b}) * FnvPrime;
  endfunction
endpackage

// File: rtl/fnv_hash_arbiter_if.sv
// fnv_hash_arbiter_if: two byte-stream requesters, digest result port and status
interface fnv_hash_arbiter_if #(parameter int LenWidth = 16);
  logic                s0_valid;
  logic [7:0]          s0_data;
  logic                s0_last;
  logic                s0_ready;
  logic                s1_valid;
  logic [7:0]          s1_data;
  logic                s1_last;
  logic                s1_ready;
  logic                d_valid;
  logic                d_ready;
  logic [31:0]         d_hash;
  logic                d_id;
  logic [LenWidth-1:0] d_len;
  logic                busy;
  modport slave (
    input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, d_ready,
    output s0_ready, s1_ready, d_valid, d_hash, d_id, d_len, busy
  );
  modport master (
    output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, d_ready,
    input  s0_ready, s1_ready, d_valid, d_hash, d_id, d_len, busy
  );
endinterface

// File: rtl/fnv_1a_32.sv
// fnv_1a_32: 32-bit FNV-1a hash core, one byte per enabled cycle
module fnv_1a_32
  import fnv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  in,
  output logic [31:0] hash
);
  logic [31:0] hash_q, hash_d;
  // fold in one byte when enabled, otherwise hold
  always_comb hash_d = en ? fnv_step(hash_q, in) : hash_q;
  // reset reloads the offset basis
  always_ff @(posedge clk) hash_q <= reset ? FnvOffsetBasis : hash_d;
  assign hash = hash_q;
endmodule

// File: rtl/fnv_hash_arbiter.sv
// fnv_hash_arbiter: round-robin front end granting the FNV-1a core per message
module fnv_hash_arbiter
  import fnv_pkg::*;
#(
  parameter int LenWidth = 16
) (
  input logic               clk,
  input logic               reset,
  fnv_hash_arbiter_if.slave bus
);
  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                ptr_q, ptr_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic                sel_valid, sel_last, hs;
  logic [7:0]          sel_data;
  logic [31:0]         core_hash;
  assign sel_valid = grant_q ? bus.s1_valid : bus.s0_valid;
  assign sel_last  = grant_q ? bus.s1_last : bus.s0_last;
  assign sel_data  = grant_q ? bus.s1_data : bus.s0_data;
  assign hs        = (state_q == ST_HASH) && sel_valid;
  fnv_1a_32 u_core (
    .clk  (clk),
    .reset(reset || (state_q == ST_SEED)),
    .en   (hs),
    .in   (sel_data),
    .hash (core_hash)
  );
  // arbitration, seeding, byte counting and result handshake
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE: if (bus.s0_valid || bus.s1_valid) begin
        grant_d = (bus.s0_valid && bus.s1_valid) ? ptr_q : bus.s1_valid;
        state_d = ST_SEED;
      end
      ST_SEED: begin
        len_d   = '0;
        state_d = ST_HASH;
      end
      ST_HASH: if (hs) begin
        len_d   = &len_q ? len_q : len_q + 1'b1;
        state_d = sel_last ? ST_DONE : ST_HASH;
      end
      ST_DONE: if (bus.d_ready) begin
        ptr_d   = ~grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state registers; reset favours requester 0 and drops any partial message
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
    end
  end
  assign bus.s0_ready = (state_q == ST_HASH) && !grant_q;
  assign bus.s1_ready = (state_q == ST_HASH) && grant_q;
  assign bus.d_valid  = (state_q == ST_DONE);
  assign bus.d_hash   = core_hash;
  assign bus.d_id     = grant_q;
  assign bus.d_len    = len_q;
  assign bus.busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fnv_hash_arbiter.sv
// tb_fnv_hash_arbiter: directed and random checks of the arbiter against a byte-level FNV-1a model
module tb_fnv_hash_arbiter;
  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] v = '0;
  logic [1:0] lst = '0;
  logic [7:0] dat [2];
  logic dr_force = 1'b1;
  logic dr_rand = 1'b1;
  logic rand_dr = 1'b0;
  fnv_hash_arbiter_if #(.LenWidth(16)) bus ();
  fnv_hash_arbiter_if #(.LenWidth(4)) bus4 ();
  assign bus.s0_valid = v[0];
  assign bus.s0_data  = dat[0];
  assign bus.s0_last  = lst[0];
  assign bus.s1_valid = v[1];
  assign bus.s1_data  = dat[1];
  assign bus.s1_last  = lst[1];
  assign bus.d_ready  = rand_dr ? dr_rand : dr_force;
  assign bus4.s0_valid = bus.s0_valid;
  assign bus4.s0_data  = bus.s0_data;
  assign bus4.s0_last  = bus.s0_last;
  assign bus4.s1_valid = bus.s1_valid;
  assign bus4.s1_data  = bus.s1_data;
  assign bus4.s1_last  = bus.s1_last;
  assign bus4.d_ready  = bus.d_ready;
  fnv_hash_arbiter #(.LenWidth(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  fnv_hash_arbiter #(.LenWidth(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  int n_chk = 0, n_fail = 0, cyc = 0, n_digest = 0, acc_cnt = 0;
  int first_acc_cyc = 0, last_acc_cyc = 0, dv_rise_cyc = 0;
  logic acc_id = 1'b0, prev_last_hs = 1'b0, prev_dv = 1'b0, prev_dr = 1'b0;
  logic [31:0] prev_hash = '0;
  bq_t exp_bytes [2];
  iq_t exp_lens [2];
  int id_log[$], len_log[$], len4_log[$], first_log[$], last_log[$], cyc_log[$];
  logic [31:0] hash_log[$];
  logic hs0, hs1;
  int mid, mn;
  bq_t mm;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] fnv_ref(input bq_t m);
    logic [31:0] h = 32'h811C9DC5;
    foreach (m[i]) h = (h ^ {24'h0, m[i]}) * 32'h01000193;
    return h;
  endfunction
  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction
  function automatic bq_t rand_msg();
    bq_t q;
    int n = $urandom_range(24, 1);
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction
  always @(negedge clk) dr_rand = ($urandom_range(3) != 0);
  // monitor: samples between drive and next rising edge
  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (reset) begin
      prev_last_hs = 1'b0;
      prev_dv = 1'b0;
      prev_dr = 1'b0;
      acc_cnt = 0;
    end else begin
      check("ready_excl", bus.s0_ready & bus.s1_ready, 0);
      check("twin_ready", {bus4.s0_ready, bus4.s1_ready}, {bus.s0_ready, bus.s1_ready});
      if (prev_last_hs) check("dv_after_last", bus.d_valid, 1);
      if (prev_dv && !prev_dr) begin
        check("dv_hold", bus.d_valid, 1);
        check("hash_hold", bus.d_hash, prev_hash);
      end
      if (prev_dv && prev_dr) check("dv_fall", bus.d_valid, 0);
      if (bus.d_valid) check("ready_in_done", bus.s0_ready | bus.s1_ready, 0);
      if (bus.d_valid && !prev_dv) dv_rise_cyc = cyc;
      hs0 = bus.s0_valid & bus.s0_ready;
      hs1 = bus.s1_valid & bus.s1_ready;
      if (hs0 || hs1) begin
        if (acc_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_cnt++;
        acc_id = hs1;
      end
      prev_last_hs = (hs0 & bus.s0_last) | (hs1 & bus.s1_last);
      if (bus.d_valid && bus.d_ready) begin
        mid = int'(bus.d_id);
        check("d_id_vs_grant", bus.d_id, acc_id);
        check("twin_dv", bus4.d_valid, 1);
        if (exp_lens[mid].size() == 0) check("digest_unexpected", 1, 0);
        else begin
          mn = exp_lens[mid].pop_front();
          mm = {};
          repeat (mn) mm.push_back(exp_bytes[mid].pop_front());
          check("d_hash", bus.d_hash, fnv_ref(mm));
          check("d_len", bus.d_len, mn > 65535 ? 65535 : mn);
          check("d_len_acc", acc_cnt, mn);
          check("twin_hash", bus4.d_hash, fnv_ref(mm));
          check("twin_len", bus4.d_len, mn > 15 ? 15 : mn);
          check("twin_id", bus4.d_id, bus.d_id);
        end
        id_log.push_back(mid);
        hash_log.push_back(bus.d_hash);
        len_log.push_back(int'(bus.d_len));
        len4_log.push_back(int'(bus4.d_len));
        first_log.push_back(first_acc_cyc);
        last_log.push_back(last_acc_cyc);
        cyc_log.push_back(cyc);
        n_digest++;
        acc_cnt = 0;
      end
      prev_dv = bus.d_valid;
      prev_dr = bus.d_ready;
      prev_hash = bus.d_hash;
    end
  end
  task automatic send(input int id, input bq_t msg, input int gap_pct, input int stop_after);
    int t;
    logic acc;
    if (stop_after < 0) begin
      exp_lens[id].push_back(msg.size());
      foreach (msg[i]) exp_bytes[id].push_back(msg[i]);
    end
    for (int i = 0; i < msg.size(); i++) begin
      if (stop_after >= 0 && i == stop_after) break;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        v[id] = 1'b0;
        @(negedge clk);
        #1;
      end
      v[id] = 1'b1;
      dat[id] = msg[i];
      lst[id] = (i == msg.size() - 1);
      t = 0;
      acc = 1'b0;
      while (!acc && t < 3000) begin
        #1;
        acc = id ? bus.s1_ready : bus.s0_ready;
        if (!acc) begin
          @(negedge clk);
          #1;
        end
        t++;
      end
      if (!acc) begin
        check("send_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      #1;
    end
    v[id] = 1'b0;
    lst[id] = 1'b0;
  endtask
  task automatic wait_digests(input int target);
    int t = 0;
    while (n_digest < target && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("digest_wait", n_digest >= target, 1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_bytes[i].delete();
      exp_lens[i].delete();
    end
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    reset = 1'b0;
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_s0_ready"}, bus.s0_ready, 0);
    check({tag, "_s1_ready"}, bus.s1_ready, 0);
    check({tag, "_d_valid"}, bus.d_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_d_id"}, bus.d_id, 0);
    check({tag, "_d_len"}, bus.d_len, 0);
    check({tag, "_d_hash"}, bus.d_hash, 32'h811C9DC5);
  endtask
  initial begin
    int t0, nb, t;
    bq_t z;
    dat[0] = '0;
    dat[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("por");
    t0 = cyc + 1;
    send(0, str2q("a"), 0, -1);
    wait_digests(1);
    check("t1_hash", hash_log[0], 32'hE40C292C);
    check("t1_id", id_log[0], 0);
    check("t1_len", len_log[0], 1);
    check("t1_latency", dv_rise_cyc - t0, 3);
    check("t1_dv_low", bus.d_valid, 0);
    send(1, str2q("foobar"), 0, -1);
    wait_digests(2);
    check("t2_hash", hash_log[1], 32'hBF9CF968);
    check("t2_id", id_log[1], 1);
    check("t2_len", len_log[1], 6);
    check("t2_stream", last_log[1] - first_log[1], 5);
    fork
      send(0, str2q("a"), 0, -1);
      send(1, str2q("b"), 0, -1);
    join
    wait_digests(4);
    check("t3_first_id", id_log[2], 0);
    check("t3_second_id", id_log[3], 1);
    check("t3_hash_a", hash_log[2], 32'hE40C292C);
    check("t3_hash_b", hash_log[3], 32'hE70C2DE5);
    send(0, str2q("x"), 0, -1);
    wait_digests(5);
    fork
      send(0, str2q("a"), 0, -1);
      send(1, str2q("b"), 0, -1);
    join
    wait_digests(7);
    check("t3b_first_id", id_log[5], 1);
    check("t3b_second_id", id_log[6], 0);
    dr_force = 1'b0;
    send(0, str2q("a"), 0, -1);
    fork
      send(1, str2q("foobar"), 0, -1);
      begin
        t = 0;
        while (!bus.d_valid && t < 20) begin
          @(negedge clk);
          #1;
          t++;
        end
        check("t4_dv", bus.d_valid, 1);
        repeat (10) begin
          @(negedge clk);
          #1;
          check("t4_hold_ready", bus.s0_ready | bus.s1_ready, 0);
        end
        check("t4_busy", bus.busy, 1);
        check("t4_hold_id", bus.d_id, 0);
        check("t4_hold_len", bus.d_len, 1);
        dr_force = 1'b1;
      end
    join
    wait_digests(9);
    check("t4_hash_a", hash_log[7], 32'hE40C292C);
    check("t4_hash_foobar", hash_log[8], 32'hBF9CF968);
    check("t4_gap", first_log[8] - cyc_log[7], 3);
    send(0, str2q("z"), 0, -1);
    wait_digests(10);
    nb = n_digest;
    send(1, str2q("foobar"), 0, 3);
    check("t5_acc3", acc_cnt, 3);
    do_reset();
    check_reset_vals("mid");
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    check("t5_no_digest", n_digest, nb);
    fork
      send(0, str2q("a"), 0, -1);
      send(1, str2q("b"), 0, -1);
    join
    wait_digests(nb + 2);
    check("t5_id", id_log[nb], 0);
    check("t5_hash", hash_log[nb], 32'hE40C292C);
    check("t5_len", len_log[nb], 1);
    repeat (20) z.push_back(8'h00);
    send(0, z, 0, -1);
    wait_digests(nb + 3);
    check("t6_len16", len_log[nb + 2], 20);
    check("t6_len4", len4_log[nb + 2], 15);
    check("t6_hash", hash_log[nb + 2], fnv_ref(z));
    rand_dr = 1'b1;
    for (int it = 0; it < 30; it++) begin
      fork
        begin
          if ($urandom_range(3) != 0) send(0, rand_msg(), int'($urandom_range(40)), -1);
        end
        begin
          if ($urandom_range(3) != 0) send(1, rand_msg(), int'($urandom_range(40)), -1);
        end
      join
    end
    t = 0;
    while ((exp_lens[0].size() != 0 || exp_lens[1].size() != 0) && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("drain", exp_lens[0].size() + exp_lens[1].size(), 0);
    rand_dr = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fnv_hash_arbiter.md
# fnv_hash_arbiter

Two-requester front end for the shared 32-bit FNV-1a hash core. Grants the core to one byte-stream requester for a whole message, seeds the core, feeds accepted bytes, and returns the final digest with requester ID and byte count over a valid/ready result port. Sits between the I2C receive path and the register/readout logic.

## Interface

**Parameters**
- `LenWidth`, default 16: width of the per-message byte counter and `d_len`.

**Ports** (name, direction, width, meaning)
- **Clock and reset:** one clock `clk`; `reset` is synchronous and active-high.
  - `clk`, input, 1: the single clock.
  - `reset`, input, 1: synchronous, active-high.
- **Requester 0 byte stream:**
  - `s0_valid`, input, 1: byte available.
  - `s0_data`, input, 8: byte.
  - `s0_last`, input, 1: byte is final of message.
  - `s0_ready`, output, 1: byte accepted when `s0_valid & s0_ready`.
- **Requester 1 byte stream:** `s1_valid`, `s1_data`, `s1_last`, `s1_ready`, same as requester 0.
- **Result port:**
  - `d_valid`, output, 1: digest available.
  - `d_ready`, input, 1: consumer takes digest.
  - `d_hash`, output, 32: FNV-1a digest.
  - `d_id`, output, 1: requester that produced the digest.
  - `d_len`, output, LenWidth: bytes hashed, saturating.
- **Status:**
  - `busy`, output, 1: high in any state other than IDLE.

## Operation

**FSM states:** IDLE, SEED, HASH, DONE.

- **IDLE**
  - Both `sN_ready` are 0.
  - If either `sN_valid` = 1, register a grant and go to SEED.
  - Arbitration is round-robin:
    - If only one requester is valid, that one is granted.
    - If both are valid, the requester not granted last is granted.
    - The priority pointer resets to favour requester 0.
- **SEED** (one cycle)
  - Drive core reset, which loads offset basis 0x811C9DC5.
  - Clear the length counter.
  - Go to HASH.
- **HASH**
  - `sN_ready` = 1 for the granted requester only; the other requester's ready is 0.
  - On each handshake:
    - assert core enable with `sN_data`;
    - increment the length counter, saturating at all-ones.
  - On a handshake with `sN_last` = 1, go to DONE.
  - No byte-count limit. Every message is at least one byte, because `last` always accompanies a byte.
- **DONE**
  - `d_valid` = 1.
  - `d_hash` = core output; the core is not enabled in this state, so the value is stable.
  - `d_id` = grant.
  - `d_len` = counter.
  - Both readies are 0.
  - On `d_valid & d_ready`:
    - go to IDLE;
    - set the priority pointer to the other requester.

**Output rules**
- Core enable is asserted only on HASH handshakes. Core reset is asserted in SEED or when `reset` = 1.
- The non-granted requester may hold `valid` indefinitely and is never dropped. It wins the next IDLE arbitration when contended.

## Timing

- **Reset values:**
  - `s0_ready`, `s1_ready`, `d_valid`, `busy` = 0.
  - `d_id` = 0, `d_len` = 0.
  - `d_hash` = 0x811C9DC5, because the core reset is driven by `reset`.
  - State = IDLE.
- **Start-up latency:** `s_valid` rises at cycle 0 (IDLE) → SEED at cycle 1 → first possible accept at cycle 2.
- **Throughput:** one byte per cycle in HASH.
- **Completion latency:** the last byte is accepted at edge E → `d_valid` = 1 in the cycle following E. The digest reflects all bytes.
- **Result hold:** `d_valid` and all `d_*` outputs hold until the handshake. `d_valid` falls the cycle after the handshake.
- **Back-to-back messages:** DONE handshake → IDLE for one cycle → SEED. The minimum gap between messages is 3 cycles with no accepted bytes.
- **Reset mid-operation:** `reset` takes effect at the next edge in any state.
  - Partial message discarded, no digest emitted.
  - Priority pointer restored to requester 0.
  - Core reseeded.
- **Length saturation:** `d_len` saturates at 2^LenWidth−1; hashing continues correctly past that point.

## Structure

- **Package `fnv_pkg`:**
  - state enum (IDLE/SEED/HASH/DONE);
  - `FnvOffsetBasis` = 32'h811C9DC5;
  - `FnvPrime` = 32'h01000193.
- **Sub-module:** one instance of the existing `fnv_1a_32` core.
  - Its reset input = `reset | (state == SEED)`.
  - Its enable input = HASH-state handshake.
  - Its `in` input = the muxed granted data.
- **Implemented in this module:**
  - requester mux;
  - round-robin pointer;
  - length counter;
  - FSM.

## Test plan

1. **Single byte, requester 0:** after reset, requester 0 sends 0x61 ("a") with last; `d_ready` = 1 → `d_hash` = 0xE40C292C, `d_id` = 0, `d_len` = 1. `d_valid` is high for exactly one cycle, and appears 3 cycles after `s0_valid` rose.
2. **Multi-byte stream, requester 1:** requester 1 streams "foobar" with no gaps → `d_hash` = 0xBF9CF968, `d_id` = 1, `d_len` = 6. `s1_ready` is continuously high for 6 cycles.
3. **Contention and round-robin:** both requesters are valid in the same cycle; requester 0 sends "a" and requester 1 sends "b". Requester 0 is served first and gives 0xE40C292C; then requester 1 gives 0xE70C2DE5. `s1_ready` stays 0 throughout requester 0's message.
4. **Result backpressure:** hold `d_ready` = 0 for 10 cycles in DONE → `d_*` stable, both readies 0, new `sN_valid` ignored. Raise `d_ready` → the next message starts after the 3-cycle gap.
5. **Reset mid-message:** assert `reset` after 3 of 6 "foobar" bytes → no `d_valid`. Then resend "a" → 0xE40C292C, `d_len` = 1, `d_id` = 0.
6. **Saturation:** with `LenWidth` = 4, send 20 bytes of 0x00 → `d_len` = 15. `d_hash` matches the reference model for 20 zero bytes.
